// File: rtl/forward_hazard_unit.sv
// Operand-forwarding and hazard control for an in-order pipeline:
// tracks in-flight writers, picks bypass sources, stalls load-use and multi-cycle ops.
module forward_hazard_unit #(
  parameter  int RAW     = 4,
  parameter  int DEPTH   = 3,
  parameter  int MUL_LAT = 4,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_src1,
  input  logic [RAW-1:0] id_src2,
  input  logic           id_use1,
  input  logic           id_use2,
  input  logic [RAW-1:0] id_dst,
  input  logic           id_wr,
  input  logic           id_load,
  input  logic           id_mul,
  input  logic           flush,
  output logic           stall,
  output logic           ex_hold,
  output logic [SW-1:0]  fwd_a,
  output logic [SW-1:0]  fwd_b,
  output logic [15:0]    stall_cnt
);

  typedef enum logic {
    RUN,
    MBUSY
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;

  logic [DEPTH:1] r_vld;
  logic [DEPTH:1] r_wr;
  logic [RAW-1:0] r_dst [DEPTH:1];
  logic           r_load1;

  logic [SW-1:0]  r_fwd_a;
  logic [SW-1:0]  r_fwd_b;
  logic [15:0]    r_stall_cnt;

  logic           w_use_a;
  logic           w_use_b;
  logic [SW-1:0]  w_sel_a;
  logic [SW-1:0]  w_sel_b;
  logic           w_lu;
  logic           w_busy;
  logic           w_stall;
  logic           w_issue;

  assign w_busy = (r_state == MBUSY);
  assign w_use_a = id_use1 && (id_src1 != '0);
  assign w_use_b = id_use2 && (id_src2 != '0);

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (w_use_a && r_vld[k] && r_wr[k] && (r_dst[k] == id_src1))
        w_sel_a = SW'(k);
      if (w_use_b && r_vld[k] && r_wr[k] && (r_dst[k] == id_src2))
        w_sel_b = SW'(k);
    end
  end

  assign w_lu = r_vld[1] && r_load1 && r_wr[1] &&
                ((w_use_a && (r_dst[1] == id_src1)) ||
                 (w_use_b && (r_dst[1] == id_src2)));

  assign w_stall = !rst && id_valid && (w_busy || w_lu);
  assign w_issue = !rst && id_valid && !w_stall && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (w_busy) begin
      w_cnt_nxt = r_cnt - 4'd1;
      if (r_cnt == 4'd1)
        w_state_nxt = RUN;
    end else if (w_issue && id_mul && (MUL_LAT > 1)) begin
      w_state_nxt = MBUSY;
      w_cnt_nxt   = 4'(MUL_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Flush squashes the EX occupant, so nothing valid moves into slot 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      for (int k = 3; k <= DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_wr[k]  <= r_wr[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      if (flush) begin
        r_vld[1] <= 1'b0;
        r_vld[2] <= 1'b0;
      end else if (w_busy) begin
        r_vld[2] <= 1'b0;
      end else begin
        r_vld[2] <= r_vld[1];
        r_wr[2]  <= r_wr[1];
        r_dst[2] <= r_dst[1];
        r_vld[1] <= w_issue;
        r_wr[1]  <= id_wr;
        r_dst[1] <= id_dst;
        r_load1  <= id_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_fwd_a <= w_issue ? w_sel_a : '0;
      r_fwd_b <= w_issue ? w_sel_b : '0;
      if (w_stall && !flush && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall     = w_stall;
  assign ex_hold   = w_busy;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall_cnt = r_stall_cnt;

endmodule
